// File: rtl/snn_pkg.sv
// Shared SNN definitions: potential encodings, ID/timestep widths, spike-event format.
package snn_pkg;

  localparam logic [31:0] FP_ZERO        = 32'h0000_0000;
  localparam logic [31:0] V_REST_DEFAULT = FP_ZERO;

  localparam int unsigned NEURON_ID_W = 6;
  localparam int unsigned TIMESTEP_W  = 16;

  typedef struct packed {
    logic [NEURON_ID_W-1:0] id;
    logic [TIMESTEP_W-1:0]  timestep;
  } spike_event_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } wb_state_e;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO for spike events; a push is accepted when full only if a pop
// happens in the same cycle.
module spike_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 22
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the outputs have defined reset values.
  assign dout = empty ? '0 : store[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) store[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/potential_writeback.sv
// Commits post-reset membrane potentials to memory, serves the forwarded read
// port, stamps spikes with the timestep and queues them for the packetizer.
module potential_writeback
  import snn_pkg::*;
#(
  parameter int unsigned NEURONS    = 64,
  parameter int unsigned ID_W       = NEURON_ID_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_W       = TIMESTEP_W,
  parameter logic [31:0] V_REST     = V_REST_DEFAULT
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          wr_valid,
  input  logic [ID_W-1:0]               wr_id,
  input  logic [31:0]                   potential_to_mem,
  input  logic                          spiked,
  input  logic                          rd_en,
  input  logic [ID_W-1:0]               rd_id,
  output logic [31:0]                   rd_potential,
  input  logic                          timestep_end,
  output logic                          spk_valid,
  input  logic                          spk_ready,
  output logic [ID_W-1:0]               spk_id,
  output logic [TS_W-1:0]               spk_timestep,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          init_done
);

  wb_state_e        state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic             mem_we;
  logic [ID_W-1:0]  mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem [NEURONS];
  logic             run;
  logic [TS_W-1:0]  ts;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ID_W+TS_W-1:0] head;

  assign run       = (state == ST_RUN);
  assign init_done = run;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // The single memory write port is shared between initialisation and the write path.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_addr  = wr_id;
    mem_wdata = potential_to_mem;
    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = V_REST;
        ptr_nxt   = ptr + ID_W'(1);
        if (ptr == ID_W'(NEURONS - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        mem_we = wr_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_potential <= '0;
    end else if (run && rd_en) begin
      rd_potential <= (wr_valid && (wr_id == rd_id)) ? potential_to_mem : mem[rd_id];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ts <= '0;
    end else if (run && timestep_end) begin
      ts <= ts + TS_W'(1);
    end
  end

  assign push = run && wr_valid && spiked;
  assign pop  = spk_valid && spk_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W + TS_W)
  ) u_spike_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .din   ({wr_id, ts}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign spk_valid    = !fifo_empty;
  assign spk_id       = head[ID_W+TS_W-1:TS_W];
  assign spk_timestep = head[TS_W-1:0];

endmodule

// File: tb/tb_potential_writeback.sv
// Directed bench for potential_writeback: init, write/read forwarding, spike FIFO,
// timestep wrap and mid-operation reset.
module tb_potential_writeback;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        wr_valid = 1'b0;
  logic [5:0]  wr_id = '0;
  logic [31:0] potential_to_mem = '0;
  logic        spiked = 1'b0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_id = '0;
  logic [31:0] rd_potential;
  logic        timestep_end = 1'b0;
  logic        spk_valid;
  logic        spk_ready = 1'b0;
  logic [5:0]  spk_id;
  logic [15:0] spk_timestep;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        init_done;

  int checks = 0;
  int failures = 0;

  potential_writeback #(
    .NEURONS    (64),
    .ID_W       (6),
    .FIFO_DEPTH (16),
    .TS_W       (16),
    .V_REST     (32'h0000_0000)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .wr_valid         (wr_valid),
    .wr_id            (wr_id),
    .potential_to_mem (potential_to_mem),
    .spiked           (spiked),
    .rd_en            (rd_en),
    .rd_id            (rd_id),
    .rd_potential     (rd_potential),
    .timestep_end     (timestep_end),
    .spk_valid        (spk_valid),
    .spk_ready        (spk_ready),
    .spk_id           (spk_id),
    .spk_timestep     (spk_timestep),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .init_done        (init_done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; spiked = 1'b0; rd_en = 1'b0; timestep_end = 1'b0; spk_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    RESET = 1'b1;
    tick();
    checks++; if (rd_potential !== 32'h0) begin failures++; $display("FAIL reset_rd_potential got=%h exp=0", rd_potential); end
    checks++; if (spk_valid !== 1'b0) begin failures++; $display("FAIL reset_spk_valid got=%b exp=0", spk_valid); end
    checks++; if (spk_id !== 6'd0 || spk_timestep !== 16'd0) begin failures++; $display("FAIL reset_head got=%0d/%0d exp=0/0", spk_id, spk_timestep); end
    checks++; if (fifo_count !== 5'd0 || overflow !== 1'b0 || init_done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0d/%b/%b exp=0/0/0", fifo_count, overflow, init_done); end
    RESET = 1'b0;
    // Activity during INIT must be ignored: no pushes, no ts increments.
    wr_valid = 1'b1; spiked = 1'b1; wr_id = 6'd5; potential_to_mem = 32'hDEAD_BEEF; timestep_end = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    idle_inputs();
    checks++; if (n != 64) begin failures++; $display("FAIL init_done_latency got=%0d exp=64", n); end
    checks++; if (fifo_count !== 5'd0 || spk_valid !== 1'b0) begin failures++; $display("FAIL init_no_push got=%0d/%b exp=0/0", fifo_count, spk_valid); end
  endtask

  task automatic test_init_read();
    rd_en = 1'b1; rd_id = 6'd0;
    tick();
    checks++; if (rd_potential !== 32'h0) begin failures++; $display("FAIL init_read0 got=%h exp=0", rd_potential); end
    rd_id = 6'd63;
    tick();
    checks++; if (rd_potential !== 32'h0) begin failures++; $display("FAIL init_read63 got=%h exp=0", rd_potential); end
    checks++; if (spk_valid !== 1'b0) begin failures++; $display("FAIL init_spk_valid got=%b exp=0", spk_valid); end
    idle_inputs();
  endtask

  task automatic test_write_read();
    wr_valid = 1'b1; wr_id = 6'd5; potential_to_mem = 32'h3F80_0000; spiked = 1'b0;
    tick();
    wr_valid = 1'b0; rd_en = 1'b1; rd_id = 6'd5;
    tick();
    checks++; if (rd_potential !== 32'h3F80_0000) begin failures++; $display("FAIL write_read5 got=%h exp=3f800000", rd_potential); end
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL no_spike_push got=%0d exp=0", fifo_count); end
    // rd_en low: output holds even though memory changes underneath.
    rd_en = 1'b0; wr_valid = 1'b1; potential_to_mem = 32'h4040_0000;
    tick();
    wr_valid = 1'b0;
    tick();
    checks++; if (rd_potential !== 32'h3F80_0000) begin failures++; $display("FAIL read_hold got=%h exp=3f800000", rd_potential); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_potential !== 32'h4040_0000) begin failures++; $display("FAIL read_after_rewrite got=%h exp=40400000", rd_potential); end
  endtask

  task automatic test_forward_spike();
    timestep_end = 1'b1;
    repeat (3) tick();
    timestep_end = 1'b0;
    wr_valid = 1'b1; wr_id = 6'd9; potential_to_mem = 32'h4000_0000; spiked = 1'b1;
    rd_en = 1'b1; rd_id = 6'd9;
    tick();
    idle_inputs();
    checks++; if (rd_potential !== 32'h4000_0000) begin failures++; $display("FAIL forward_read got=%h exp=40000000", rd_potential); end
    checks++; if (spk_valid !== 1'b1 || spk_id !== 6'd9 || spk_timestep !== 16'd3) begin failures++; $display("FAIL spike_head got=%b/%0d/%0d exp=1/9/3", spk_valid, spk_id, spk_timestep); end
    checks++; if (fifo_count !== 5'd1) begin failures++; $display("FAIL spike_count got=%0d exp=1", fifo_count); end
    spk_ready = 1'b1;
    tick();
    spk_ready = 1'b0;
    checks++; if (spk_valid !== 1'b0 || fifo_count !== 5'd0) begin failures++; $display("FAIL spike_pop got=%b/%0d exp=0/0", spk_valid, fifo_count); end
    // Pop request on an empty FIFO is ignored.
    spk_ready = 1'b1;
    tick();
    spk_ready = 1'b0;
    checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL empty_pop got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_id;
    spk_ready = 1'b0; spiked = 1'b1; wr_valid = 1'b1; potential_to_mem = 32'h0;
    for (int i = 0; i < 17; i++) begin
      wr_id = 6'(10 + i);
      tick();
    end
    idle_inputs();
    checks++; if (fifo_count !== 5'd16 || overflow !== 1'b1) begin failures++; $display("FAIL full_state got=%0d/%b exp=16/1", fifo_count, overflow); end
    tick();
    checks++; if (spk_id !== 6'd10 || spk_timestep !== 16'd3) begin failures++; $display("FAIL full_head_stable got=%0d/%0d exp=10/3", spk_id, spk_timestep); end
    wr_valid = 1'b1; spiked = 1'b1; wr_id = 6'd40; spk_ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (fifo_count !== 5'd16 || spk_id !== 6'd11) begin failures++; $display("FAIL full_push_pop got=%0d/%0d exp=16/11", fifo_count, spk_id); end
    spk_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_id = (i < 15) ? 6'(11 + i) : 6'd40;
      checks++; if (spk_valid !== 1'b1 || spk_id !== exp_id) begin failures++; $display("FAIL drain_%0d got=%b/%0d exp=1/%0d", i, spk_valid, spk_id, exp_id); end
      tick();
    end
    spk_ready = 1'b0;
    checks++; if (fifo_count !== 5'd0 || spk_valid !== 1'b0 || overflow !== 1'b1) begin failures++; $display("FAIL drained got=%0d/%b/%b exp=0/0/1", fifo_count, spk_valid, overflow); end
  endtask

  task automatic test_ts_wrap();
    // ts is 3 here; 65532 pulses reach 65535, the next pulse wraps.
    timestep_end = 1'b1;
    repeat (65532) tick();
    wr_valid = 1'b1; spiked = 1'b1; wr_id = 6'd7;
    tick();
    wr_id = 6'd8; timestep_end = 1'b0;
    tick();
    idle_inputs();
    checks++; if (spk_id !== 6'd7 || spk_timestep !== 16'd65535) begin failures++; $display("FAIL wrap_stamp got=%0d/%0d exp=7/65535", spk_id, spk_timestep); end
    spk_ready = 1'b1;
    tick();
    spk_ready = 1'b0;
    checks++; if (spk_id !== 6'd8 || spk_timestep !== 16'd0) begin failures++; $display("FAIL after_wrap_stamp got=%0d/%0d exp=8/0", spk_id, spk_timestep); end
    spk_ready = 1'b1;
    tick();
    spk_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    wr_valid = 1'b1; wr_id = 6'd5; potential_to_mem = 32'h1234_5678;
    tick();
    wr_valid = 1'b0; rd_en = 1'b1; rd_id = 6'd5; timestep_end = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    timestep_end = 1'b0;
    wr_valid = 1'b1; spiked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_id = 6'(1 + i);
      tick();
    end
    idle_inputs();
    spk_ready = 1'b1;
    tick();
    checks++; if (fifo_count !== 5'd5 || rd_potential !== 32'h1234_5678) begin failures++; $display("FAIL pre_reset got=%0d/%h exp=5/12345678", fifo_count, rd_potential); end
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (rd_potential !== 32'h0 || spk_valid !== 1'b0 || spk_id !== 6'd0 || spk_timestep !== 16'd0) begin failures++; $display("FAIL midreset_outputs got=%h/%b/%0d/%0d exp=0/0/0/0", rd_potential, spk_valid, spk_id, spk_timestep); end
    checks++; if (fifo_count !== 5'd0 || overflow !== 1'b0 || init_done !== 1'b0) begin failures++; $display("FAIL midreset_flags got=%0d/%b/%b exp=0/0/0", fifo_count, overflow, init_done); end
    idle_inputs();
    tick();
    RESET = 1'b0;
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (n != 64) begin failures++; $display("FAIL reinit_latency got=%0d exp=64", n); end
    rd_en = 1'b1; rd_id = 6'd5; wr_valid = 1'b1; spiked = 1'b1; wr_id = 6'd20;
    tick();
    idle_inputs();
    checks++; if (rd_potential !== 32'h0) begin failures++; $display("FAIL reinit_read5 got=%h exp=0", rd_potential); end
    checks++; if (spk_id !== 6'd20 || spk_timestep !== 16'd0 || fifo_count !== 5'd1) begin failures++; $display("FAIL ts_cleared got=%0d/%0d/%0d exp=20/0/1", spk_id, spk_timestep, fifo_count); end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_write_read();
    test_forward_spike();
    test_overflow();
    test_ts_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/potential_writeback.md
# potential_writeback

Stage directly downstream of the membrane-potential reset unit. Each update cycle it commits the post-reset potential (`potential_to_mem`) of one neuron into an on-chip potential memory and, if that neuron spiked, enqueues its ID, stamped with the current timestep, into a spike-event FIFO for the NoC packetizer. It also serves the potential read port used by the accumulate stage in the next timestep, and initialises every potential to `V_REST` after reset.

## Interface
- `NEURONS`, 64: neurons held in memory. Power of two, ≥2.
- `ID_W`, 6: neuron ID width. Equals log2(`NEURONS`).
- `FIFO_DEPTH`, 16: spike FIFO entries. Power of two.
- `TS_W`, 16: timestep counter width.
- `V_REST`, 32'h0000_0000: IEEE-754 single rest potential (+0.0).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high.
- `wr_valid` in 1: `potential_to_mem`/`spiked` valid for `wr_id` this cycle.
- `wr_id` in `ID_W`: neuron being written.
- `potential_to_mem` in 32: post-reset potential, IEEE-754 single.
- `spiked` in 1: neuron fired this update.
- `rd_en` in 1: read request.
- `rd_id` in `ID_W`: neuron to read.
- `rd_potential` out 32: read data, 1-cycle latency.
- `timestep_end` in 1: single-cycle pulse that closes the current timestep.
- `spk_valid` out 1: FIFO head valid.
- `spk_ready` in 1: consumer accepts head.
- `spk_id` out `ID_W`: spiking neuron ID.
- `spk_timestep` out `TS_W`: timestep in which the spike occurred.
- `fifo_count` out log2(`FIFO_DEPTH`)+1: occupancy.
- `overflow` out 1: sticky; a spike was dropped.
- `init_done` out 1: memory initialisation complete.

## Operation
- FSM states: `INIT` and `RUN`.
  - `RESET` forces `INIT`, with the init pointer at 0.
  - `INIT` writes `V_REST` to address `ptr`, one address per cycle. After address `NEURONS-1` it moves to `RUN` and sets `init_done`.
  - `RUN` is held until the next `RESET`.
- In `INIT`, `wr_valid`, `rd_en` and `timestep_end` are ignored, and no FIFO push occurs.
- Write path (`RUN`): when `wr_valid` is high, `mem[wr_id] <= potential_to_mem`. If `spiked` is also high, push `{wr_id, ts}`. `spiked` is ignored when `wr_valid` is low.
- Read path (`RUN`): when `rd_en` is high, `rd_potential <= mem[rd_id]`, with write-forwarding. If `wr_valid` is high and `wr_id == rd_id` in the same cycle, `rd_potential` takes the new `potential_to_mem`. When `rd_en` is low, `rd_potential` holds its value.
- Timestep counter `ts` increments on `timestep_end` and wraps from 2^TS_W−1 to 0. A push in the same cycle as `timestep_end` is stamped with the old `ts`.
- FIFO pop occurs when `spk_valid && spk_ready`. `spk_id`/`spk_timestep` show the head entry and are stable while `spk_valid && !spk_ready`.
- Full FIFO:
  - A push with no simultaneous pop is dropped and sets `overflow`.
  - Push and pop in the same cycle when full both succeed; count stays `FIFO_DEPTH`.
- Empty FIFO: a pop request is ignored, and `spk_valid` is low.
- `overflow` clears only on `RESET`.

## Timing
- Values on reset: `rd_potential`=0, `spk_valid`=0, `spk_id`=0, `spk_timestep`=0, `fifo_count`=0, `overflow`=0, `init_done`=0, `ts`=0.
- `init_done` rises at the clock edge `NEURONS` cycles after `RESET` deasserts.
- Memory write is visible to a read issued on the following cycle, or the same cycle through forwarding.
- Read latency: 1 cycle.
- Push to `spk_valid`: 1 cycle. The entry is visible the cycle after the push edge.
- Sustained throughput: one write plus one read plus one pop per cycle.
- `RESET` asserted mid-operation:
  - FIFO contents are discarded and `ts` is cleared.
  - `INIT` restarts from address 0. Memory is re-initialised after release.

## Structure
- Shared package `snn_pkg` holds:
  - `FP_ZERO` (32'h0) and the `V_REST` default;
  - the ID/timestep width constants;
  - the spike-event typedef `{id, timestep}`, shared with the packetizer.
- Sub-module: `spike_fifo`, a synchronous FIFO of (`ID_W`+`TS_W`)-bit entries. It provides push/pop/full/empty/count and uses the same `CLK`/`RESET`.
- The top level contains the potential memory, the init FSM, the forwarding mux and the `ts` counter.

## Test plan
- Reset, then idle:
  - `init_done` rises after exactly 64 cycles.
  - A read of neurons 0 and 63 returns 32'h0.
  - `spk_valid`=0.
- Write neuron 5 = 32'h3F80_0000 with `spiked`=0, read 5 on the next cycle → 32'h3F80_0000. No FIFO push.
- Same-cycle write and read of neuron 9 = 32'h4000_0000 with `spiked`=1, `ts`=3:
  - `rd_potential`=32'h4000_0000 the next cycle.
  - FIFO head = {9, 3} one cycle after the push.
- Hold `spk_ready`=0 and push 17 spikes:
  - `fifo_count`=16 and `overflow`=1.
  - Draining yields the first 16 IDs in order.
  - Push+pop while full keeps count at 16.
- Pulse `timestep_end` 65 536 times with `TS_W`=16 → `ts` wraps to 0. A spike in the same cycle as the wrapping pulse is stamped 65 535.
- Assert `RESET` mid-drain with 5 entries queued and memory written → all outputs return to reset values, `init_done` low for 64 cycles, neuron 5 reads 0 afterwards.
